// File: rtl/ace_rename_pkg.sv
// Shared rename-stage constants: store-set id width and the per-slot select encodings.
package ace_rename_pkg;

   localparam int unsigned SSID_W = 7;

   // Select width covers in-bundle indices plus the LFST and previous-bundle codes.
   function automatic int unsigned sel_w(input int unsigned width);
      return $clog2(width + 2);
   endfunction

   function automatic int unsigned sel_lfst(input int unsigned width);
      return width;
   endfunction

   function automatic int unsigned sel_prv(input int unsigned width);
      return width + 1;
   endfunction

endpackage

// File: rtl/ssid_dep_chk_if.sv
// Bundle-in / select-out handshake bundle for ssid_dep_chk.
interface ssid_dep_chk_if
   import ace_rename_pkg::*;
#(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned SSID_W = ace_rename_pkg::SSID_W
);
   localparam int unsigned SEL_W = sel_w(WIDTH);
   localparam int unsigned PRV_W = $clog2(WIDTH);

   logic                      flush;
   logic                      bdl_vld;
   logic                      bdl_rdy;
   logic [WIDTH*SSID_W-1:0]   ssid;
   logic [WIDTH-1:0]          ssid_vld;
   logic [WIDTH-1:0]          store;
   logic                      out_vld;
   logic                      out_rdy;
   logic [WIDTH*SEL_W-1:0]    sel;
   logic [WIDTH*PRV_W-1:0]    prv_slot;

   modport master (
      output flush, bdl_vld, ssid, ssid_vld, store, out_rdy,
      input  bdl_rdy, out_vld, sel, prv_slot
   );

   modport slave (
      input  flush, bdl_vld, ssid, ssid_vld, store, out_rdy,
      output bdl_rdy, out_vld, sel, prv_slot
   );

endinterface

// File: rtl/ssid_prio_sel.sv
// Priority encoder: returns the highest (youngest) set index of a match vector plus a hit flag.
module ssid_prio_sel #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     match_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             hit_o
);

   always_comb begin
      idx_o = '0;
      hit_o = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         if (match_i[k]) begin
            idx_o = IDX_W'(k);
            hit_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ssid_dep_chk.sv
// Store-set dependency check: per-slot source select for a rename bundle, one-cycle latency.
// Define SSID_XBUNDLE_BYP_EN to build the previous-bundle store record (sel = WIDTH+1).
module ssid_dep_chk
   import ace_rename_pkg::*;
#(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned SSID_W = ace_rename_pkg::SSID_W
) (
   input logic           clk_i,
   input logic           rst_n_i,
   ssid_dep_chk_if.slave bus
);

   localparam int unsigned      SEL_W   = sel_w(WIDTH);
   localparam int unsigned      PRV_W   = $clog2(WIDTH);
   localparam logic [SEL_W-1:0] SelLfst = SEL_W'(sel_lfst(WIDTH));
   localparam logic [SEL_W-1:0] SelPrv  = SEL_W'(sel_prv(WIDTH));

   logic [WIDTH-1:0][SSID_W-1:0] ssid;
   logic [WIDTH-1:0]             ssid_vld;
   logic [WIDTH-1:0]             store;
   logic                         bdl_rdy;
   logic                         accept;
   logic                         out_vld_q;
   logic [WIDTH-1:0][SEL_W-1:0]  sel_d, sel_q;
   logic [WIDTH-1:0][PRV_W-1:0]  prv_slot_d, prv_slot_q;
   logic                         rec_live;
   logic [WIDTH-1:0][SSID_W-1:0] rec_ssid;
   logic [WIDTH-1:0]             rec_st;

   assign ssid     = bus.ssid;
   assign ssid_vld = bus.ssid_vld;
   assign store    = bus.store;

   assign bdl_rdy     = (~out_vld_q | bus.out_rdy) & ~bus.flush;
   assign accept      = bus.bdl_vld & bdl_rdy;
   assign bus.bdl_rdy = bdl_rdy;

`ifdef SSID_XBUNDLE_BYP_EN
   logic                         rec_live_q;
   logic [WIDTH-1:0][SSID_W-1:0] rec_ssid_q;
   logic [WIDTH-1:0]             rec_st_q;

   // Record is only useful to the very next acceptance; by then the LFST holds it anyway.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rec_live_q <= 1'b0;
         rec_ssid_q <= '0;
         rec_st_q   <= '0;
      end else if (bus.flush) begin
         rec_live_q <= 1'b0;
         rec_ssid_q <= '0;
         rec_st_q   <= '0;
      end else begin
         rec_live_q <= accept;
         if (accept) begin
            rec_ssid_q <= ssid;
            rec_st_q   <= store & ssid_vld;
         end
      end
   end

   assign rec_live = rec_live_q;
   assign rec_ssid = rec_ssid_q;
   assign rec_st   = rec_st_q;
`else
   assign rec_live = 1'b0;
   assign rec_ssid = '0;
   assign rec_st   = '0;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_slot
      logic [WIDTH-1:0] in_match;
      logic [WIDTH-1:0] prv_match;
      logic [PRV_W-1:0] in_idx, prv_idx;
      logic             in_hit, prv_hit;

      for (genvar k = 0; k < WIDTH; k++) begin : g_src
         if (k < i) begin : g_older
            assign in_match[k] = store[k] & ssid_vld[k] & ssid_vld[i] & (ssid[k] == ssid[i]);
         end else begin : g_younger
            assign in_match[k] = 1'b0;
         end
         assign prv_match[k] = rec_live & rec_st[k] & ssid_vld[i] & (rec_ssid[k] == ssid[i]);
      end

      ssid_prio_sel #(
         .N     (WIDTH),
         .IDX_W (PRV_W)
      ) u_in_sel (
         .match_i (in_match),
         .idx_o   (in_idx),
         .hit_o   (in_hit)
      );

      ssid_prio_sel #(
         .N     (WIDTH),
         .IDX_W (PRV_W)
      ) u_prv_sel (
         .match_i (prv_match),
         .idx_o   (prv_idx),
         .hit_o   (prv_hit)
      );

      assign sel_d[i]      = in_hit ? SEL_W'(in_idx) : (prv_hit ? SelPrv : SelLfst);
      assign prv_slot_d[i] = (!in_hit && prv_hit) ? prv_idx : '0;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         out_vld_q  <= 1'b0;
         sel_q      <= {WIDTH{SelLfst}};
         prv_slot_q <= '0;
      end else begin
         if (bus.flush) begin
            out_vld_q <= 1'b0;
         end else if (accept) begin
            out_vld_q <= 1'b1;
         end else if (bus.out_rdy) begin
            out_vld_q <= 1'b0;
         end
         if (accept) begin
            sel_q      <= sel_d;
            prv_slot_q <= prv_slot_d;
         end
      end
   end

   assign bus.out_vld  = out_vld_q;
   assign bus.sel      = sel_q;
   assign bus.prv_slot = prv_slot_q;

endmodule

// File: tb/tb_ssid_dep_chk.sv
// Scoreboard bench for ssid_dep_chk (WIDTH=4, SSID_W=7); expectations follow SSID_XBUNDLE_BYP_EN.
module tb_ssid_dep_chk;

   localparam int unsigned WIDTH  = 4;
   localparam int unsigned SSID_W = 7;

`ifdef SSID_XBUNDLE_BYP_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      int         id;
      logic [11:0] sel;
      logic [7:0]  prv;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   n_id   = 0;

   ssid_dep_chk_if #(.WIDTH(WIDTH), .SSID_W(SSID_W)) bus ();

   ssid_dep_chk #(
      .WIDTH  (WIDTH),
      .SSID_W (SSID_W)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [27:0] pk_ssid(input int s0, input int s1, input int s2, input int s3);
      return {7'(s3), 7'(s2), 7'(s1), 7'(s0)};
   endfunction

   function automatic logic [11:0] pk_sel(input int s0, input int s1, input int s2, input int s3);
      return {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
   endfunction

   function automatic logic [3:0] v4(input bit b0, input bit b1, input bit b2, input bit b3);
      return {b3, b2, b1, b0};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic idle(input int n);
      bus.bdl_vld = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Presents a bundle, records its expectation when accepted, returns just after the edge.
   task automatic drive(input logic [27:0] s, input logic [3:0] v, input logic [3:0] st,
                        input logic [11:0] esel, input logic [7:0] eprv);
      bit   ok;
      exp_t e;
      ok = 1'b0;
      bus.bdl_vld  = 1'b1;
      bus.ssid     = s;
      bus.ssid_vld = v;
      bus.store    = st;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (bus.bdl_rdy) begin
            e.id  = n_id++;
            e.sel = esel;
            e.prv = eprv;
            exp_q.push_back(e);
            ok = 1'b1;
         end
      end
      check("accept", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_vld && bus.out_rdy) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 32'(bus.sel), 32'hffff_ffff);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("sel#%0d", e.id), 32'(bus.sel), 32'(e.sel));
               check($sformatf("prv_slot#%0d", e.id), 32'(bus.prv_slot), 32'(e.prv));
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst_n        = 1'b0;
      bus.flush    = 1'b0;
      bus.bdl_vld  = 1'b0;
      bus.ssid     = '0;
      bus.ssid_vld = '0;
      bus.store    = '0;
      bus.out_rdy  = 1'b1;
      #12;
      check("rst_out_vld", 32'(bus.out_vld), 32'd0);
      check("rst_sel", 32'(bus.sel), 32'(pk_sel(4, 4, 4, 4)));
      check("rst_prv_slot", 32'(bus.prv_slot), 32'd0);
      check("rst_bdl_rdy", 32'(bus.bdl_rdy), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // In-bundle forwarding picks the youngest older store.
      drive(pk_ssid(5, 5, 5, 5), 4'hf, v4(1, 0, 1, 0), pk_sel(4, 0, 0, 2), 8'h00);
      idle(2);
      // Invalid slots neither match nor get forwarded.
      drive(pk_ssid(3, 3, 3, 3), v4(1, 1, 0, 1), 4'hf, pk_sel(4, 0, 4, 1), 8'h00);
      idle(2);
      drive(pk_ssid(1, 2, 1, 2), 4'hf, v4(1, 1, 0, 0), pk_sel(4, 4, 0, 1), 8'h00);
      idle(2);

      // Back-to-back: younger bundle sees the older bundle's store.
      drive(pk_ssid(0, 0, 0, 9), v4(0, 0, 0, 1), v4(0, 0, 0, 1), pk_sel(4, 4, 4, 4), 8'h00);
      drive(pk_ssid(0, 9, 0, 0), v4(0, 1, 0, 0), 4'h0,
            BYP ? pk_sel(4, 5, 4, 4) : pk_sel(4, 4, 4, 4), BYP ? 8'b0000_1100 : 8'h00);
      idle(2);

      // One idle cycle in between: record expired.
      drive(pk_ssid(0, 0, 0, 9), v4(0, 0, 0, 1), v4(0, 0, 0, 1), pk_sel(4, 4, 4, 4), 8'h00);
      idle(1);
      drive(pk_ssid(0, 9, 0, 0), v4(0, 1, 0, 0), 4'h0, pk_sel(4, 4, 4, 4), 8'h00);
      idle(2);

      // Youngest previous-bundle store wins; in-bundle beats previous-bundle.
      drive(pk_ssid(9, 9, 4, 4), 4'hf, v4(1, 1, 0, 1), pk_sel(4, 0, 4, 4), 8'h00);
      drive(pk_ssid(9, 4, 4, 7), 4'hf, v4(0, 1, 0, 0),
            BYP ? pk_sel(5, 5, 1, 4) : pk_sel(4, 4, 1, 4), BYP ? 8'b0000_1101 : 8'h00);
      idle(3);

      // Backpressure: output holds, input blocked, stall expires the record.
      bus.out_rdy = 1'b0;
      drive(pk_ssid(5, 5, 5, 5), 4'hf, v4(1, 0, 1, 0), pk_sel(4, 0, 0, 2), 8'h00);
      bus.ssid     = pk_ssid(5, 0, 0, 0);
      bus.ssid_vld = v4(1, 0, 0, 0);
      bus.store    = 4'h0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("stall_bdl_rdy_c%0d", c), 32'(bus.bdl_rdy), 32'd0);
         check($sformatf("stall_out_vld_c%0d", c), 32'(bus.out_vld), 32'd1);
         check($sformatf("stall_sel_c%0d", c), 32'(bus.sel), 32'(pk_sel(4, 0, 0, 2)));
      end
      @(posedge clk);
      #1;
      bus.out_rdy = 1'b1;
      drive(pk_ssid(5, 0, 0, 0), v4(1, 0, 0, 0), 4'h0, pk_sel(4, 4, 4, 4), 8'h00);
      bus.bdl_vld = 1'b0;
      @(negedge clk);
      check("no_bubble_out_vld", 32'(bus.out_vld), 32'd1);
      idle(3);

      // Flush with a pending output and a live record.
      bus.out_rdy = 1'b0;
      drive(pk_ssid(0, 0, 0, 9), v4(0, 0, 0, 1), v4(0, 0, 0, 1), pk_sel(4, 4, 4, 4), 8'h00);
      bus.flush    = 1'b1;
      bus.ssid     = pk_ssid(0, 9, 0, 0);
      bus.ssid_vld = v4(0, 1, 0, 0);
      bus.store    = 4'h0;
      @(negedge clk);
      check("flush_bdl_rdy", 32'(bus.bdl_rdy), 32'd0);
      @(posedge clk);
      #1;
      bus.flush   = 1'b0;
      bus.bdl_vld = 1'b0;
      bus.out_rdy = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("flush_out_vld", 32'(bus.out_vld), 32'd0);
      @(posedge clk);
      #1;
      drive(pk_ssid(0, 9, 0, 0), v4(0, 1, 0, 0), 4'h0, pk_sel(4, 4, 4, 4), 8'h00);
      idle(3);

      // Asynchronous reset in the middle of a stall drops the pending output.
      bus.out_rdy = 1'b0;
      drive(pk_ssid(5, 5, 5, 5), 4'hf, v4(1, 0, 1, 0), pk_sel(4, 0, 0, 2), 8'h00);
      bus.bdl_vld = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("arst_out_vld", 32'(bus.out_vld), 32'd0);
      check("arst_sel", 32'(bus.sel), 32'(pk_sel(4, 4, 4, 4)));
      check("arst_prv_slot", 32'(bus.prv_slot), 32'd0);
      @(negedge clk);
      rst_n       = 1'b1;
      bus.out_rdy = 1'b1;
      @(posedge clk);
      #1;
      drive(pk_ssid(5, 5, 5, 5), 4'hf, v4(1, 0, 1, 0), pk_sel(4, 0, 0, 2), 8'h00);
      idle(4);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
